seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter: DIV, default 4, clocks per digit slot; legal range 2..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 Port: en  input  1  scan enable; low = display dark, scan frozen.
REQ-005 Port: load  input  1  one-cycle request to capture bcd_in/dp_in.
REQ-006 Port: bcd_in  input  16  four BCD digits; [3:0] = digit 0 (LSD), [15:12] = digit 3 (MSD).
REQ-007 Port: dp_in  input  4  decimal point per digit; bit k belongs to digit k.
REQ-008 Port: lzb  input  1  leading-zero blanking enable.
REQ-009 Port: seg  output  7  segments {a,b,c,d,e,f,g}, bit 6 = a, active high.
REQ-010 Port: dp  output  1  decimal point of the active digit, active high.
REQ-011 Port: an_n  output  4  digit anodes, active low; bit k drives digit k.
REQ-012 Port: load_ack  output  1  one-cycle pulse when pending data reaches the display register.
REQ-013 Port: frame_start  output  1  high during the blank cycle of digit 0.

Function
REQ-014 Single shared BCD-to-7-segment decoder, time-multiplexed across all four digits.
REQ-015 Decode table (hex): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B; codes 10..15 decode to 00.
REQ-016 State: digit index idx (0..3), slot counter cnt (0..DIV-1), display register disp (16b data + 4b dp), pending register pend (16b + 4b), pending flag pf.
REQ-017 Two-state FSM per slot: BLANK when cnt==0, SHOW when cnt in 1..DIV-1.
REQ-018 With en=1: cnt increments each cycle; when cnt==DIV-1, cnt wraps to 0 and idx advances (3 wraps to 0); frame = 4*DIV cycles.
REQ-019 BLANK: an_n=1111, seg=00, dp=0 (anti-ghosting gap).
REQ-020 SHOW: an_n bit idx low, all others high; seg = decode(disp digit idx); dp = disp dp bit idx.
REQ-021 Outputs are Moore functions of registered state only; no combinational path from any input to any output.
REQ-022 load=1 in any cycle: pend <= {bcd_in, dp_in}, pf <= 1; a later load before transfer overwrites pend (last write wins).
REQ-023 Transfer: on the clock edge that enters BLANK of idx 0 with pf=1: disp <= pend, pf <= 0, load_ack high for that BLANK cycle only.
REQ-024 load on that same edge: transfer uses the old pend; new data is written to pend and pf stays 1 for the next frame.
REQ-025 Transfer only at frame boundaries; no mid-frame update of disp (no tearing).
REQ-026 lzb=1: digit k (k=1..3) is blanked (seg=00, dp still driven, anode still active) if disp digits k..3 are all 0; digit 0 never blanked; code >9 counts as non-zero.
REQ-027 lzb is sampled live during SHOW, not latched at the frame boundary.
REQ-028 en=0: cnt, idx hold; an_n=1111, seg=00, dp=0, frame_start=0; load still captured into pend; no transfer and no load_ack.
REQ-029 en rising: scan resumes from the held idx/cnt on the next edge.

Reset
REQ-030 rst_n low, asynchronously: idx=0, cnt=0, disp=0, pend=0, pf=0.
REQ-031 During reset: an_n=1111, seg=00, dp=0, load_ack=0, frame_start=0.
REQ-032 First cycle after release with en=1 is BLANK of digit 0; frame_start=1 and load_ack=0 in that cycle.
REQ-033 Reset mid-frame discards pending data; no load_ack is issued for it.

Verification
REQ-034 Reset release, en=1, DIV=4, no load -> frame_start every 16 cycles; an_n per frame: 1111,1110x3,1111,1101x3,1111,1011x3,1111,0111x3; seg=7E whenever an anode is active.
REQ-035 load with bcd_in=0x1234, dp_in=0001 mid-frame -> disp unchanged until the next idx-0 BLANK; load_ack pulses once there; next frame seg: d0=33 dp=1, d1=79, d2=6D, d3=30.
REQ-036 Load 0x0007 and lzb=1 -> digits 3..1 show seg=00 with anodes still cycling; digit 0 shows 70; lzb=0 -> digits 3..1 show 7E.
REQ-037 Loads 0x1111 then 0x2222 in one frame, then a third load (0x3333) on the transfer edge -> one ack; frame shows 2222; next boundary shows 3333 with a second ack.
REQ-038 en=0 for 10 cycles mid-SHOW -> an_n=1111 and counters frozen; a load during this window gives no ack; on re-enable the scan continues from the same idx/cnt.
REQ-039 rst_n asserted asynchronously mid-SHOW with pf=1 -> outputs go to reset values before the next edge; after release no load_ack appears and disp=0.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Purpose : signal bundle between a host and the 4-digit 7-segment scanner.
// Ports   : host side drives en/load/bcd_in/dp_in/lzb; scanner drives seg/dp/an_n/
//           load_ack/frame_start. master = host, slave = scanner.
interface seg7_scan_ctrl_if;
  logic        en;
  logic        load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        lzb;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an_n;
  logic        load_ack;
  logic        frame_start;

  modport master (
    output en, load, bcd_in, dp_in, lzb,
    input  seg, dp, an_n, load_ack, frame_start
  );

  modport slave (
    input  en, load, bcd_in, dp_in, lzb,
    output seg, dp, an_n, load_ack, frame_start
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Purpose : time-multiplexed 4-digit BCD 7-segment driver, one shared decoder,
//           blank gap before every digit, tear-free frame-boundary data update.
// Latency : en/lzb act one clock after they are sampled; load reaches the display
//           at the next idx-0 BLANK edge.
// Backpres: none; load is always accepted into a single pending slot, last write wins.
// Ports   : clk, rst_n (async, active low); bus (slave) carries en, load, bcd_in,
//           dp_in, lzb in and seg, dp, an_n, load_ack, frame_start out.
module seg7_scan_ctrl #(
  parameter int unsigned DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  seg7_scan_ctrl_if.slave  bus
);

  localparam logic [7:0] CNT_MAX  = 8'(DIV - 1);
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] disp_bcd_q, disp_bcd_d;
  logic [3:0]  disp_dp_q, disp_dp_d;
  logic [15:0] pend_bcd_q, pend_bcd_d;
  logic [3:0]  pend_dp_q, pend_dp_d;
  logic        pf_q, pf_d;
  logic        ack_q, ack_d;
  // en and lzb are registered so every output depends on flops only.
  logic        en_q;
  logic        lzb_q;

  logic        wrap_w;
  logic        xfer_w;
  logic [0:0]  state_w;
  logic [3:0]  dig_w;
  logic        z1_w, z2_w, z3_w;
  logic        lz_blank_w;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'h7E;
      4'd1:    seg_decode = 7'h30;
      4'd2:    seg_decode = 7'h6D;
      4'd3:    seg_decode = 7'h79;
      4'd4:    seg_decode = 7'h33;
      4'd5:    seg_decode = 7'h5B;
      4'd6:    seg_decode = 7'h5F;
      4'd7:    seg_decode = 7'h70;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h7B;
      default: seg_decode = 7'h00;
    endcase
  endfunction

  // Scan only advances across a cycle that was actually displayed (en_q=1).
  assign wrap_w = en_q && (cnt_q == CNT_MAX);
  // The edge leaving digit 3's last slot is the edge entering BLANK of digit 0.
  assign xfer_w = wrap_w && (idx_q == 2'd3) && pf_q;

  always_comb begin
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    disp_bcd_d = disp_bcd_q;
    disp_dp_d  = disp_dp_q;
    pend_bcd_d = pend_bcd_q;
    pend_dp_d  = pend_dp_q;
    pf_d       = pf_q;
    ack_d      = 1'b0;
    if (en_q) begin
      if (wrap_w) begin
        cnt_d = 8'd0;
        idx_d = idx_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
    if (xfer_w) begin
      disp_bcd_d = pend_bcd_q;
      disp_dp_d  = pend_dp_q;
      pf_d       = 1'b0;
      ack_d      = 1'b1;
    end
    // A load on the transfer edge wins over the clear: new data waits a frame.
    if (bus.load) begin
      pend_bcd_d = bus.bcd_in;
      pend_dp_d  = bus.dp_in;
      pf_d       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= 8'd0;
      idx_q      <= 2'd0;
      disp_bcd_q <= 16'd0;
      disp_dp_q  <= 4'd0;
      pend_bcd_q <= 16'd0;
      pend_dp_q  <= 4'd0;
      pf_q       <= 1'b0;
      ack_q      <= 1'b0;
      en_q       <= 1'b0;
      lzb_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_bcd_q <= disp_bcd_d;
      disp_dp_q  <= disp_dp_d;
      pend_bcd_q <= pend_bcd_d;
      pend_dp_q  <= pend_dp_d;
      pf_q       <= pf_d;
      ack_q      <= ack_d;
      en_q       <= bus.en;
      lzb_q      <= bus.lzb;
    end
  end

  assign state_w = (cnt_q == 8'd0) ? ST_BLANK : ST_SHOW;
  assign dig_w   = disp_bcd_q[{idx_q, 2'b00} +: 4];

  // zN: digits N..3 are all zero (codes above 9 count as non-zero).
  assign z3_w = (disp_bcd_q[15:12] == 4'd0);
  assign z2_w = z3_w && (disp_bcd_q[11:8] == 4'd0);
  assign z1_w = z2_w && (disp_bcd_q[7:4] == 4'd0);

  always_comb begin
    lz_blank_w = 1'b0;
    case (idx_q)
      2'd1:    lz_blank_w = z1_w;
      2'd2:    lz_blank_w = z2_w;
      2'd3:    lz_blank_w = z3_w;
      default: lz_blank_w = 1'b0;
    endcase
    lz_blank_w = lz_blank_w && lzb_q;
  end

  always_comb begin
    bus.an_n = 4'b1111;
    bus.seg  = 7'h00;
    bus.dp   = 1'b0;
    if (en_q && (state_w == ST_SHOW)) begin
      bus.an_n = ~(4'b0001 << idx_q);
      bus.seg  = lz_blank_w ? 7'h00 : seg_decode(dig_w);
      bus.dp   = disp_dp_q[idx_q];
    end
  end

  assign bus.frame_start = en_q && (state_w == ST_BLANK) && (idx_q == 2'd0);
  assign bus.load_ack    = ack_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Purpose : directed self-checking bench for seg7_scan_ctrl with DIV=4 (16-cycle frame).
// Latency : outputs sampled on the falling edge, inputs driven there too.
// Backpres: n/a.
module tb_seg7_scan_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  int          ld_p   [3];
  logic [15:0] ld_bcd [3];
  logic [3:0]  ld_dp  [3];

  seg7_scan_ctrl_if bus_if ();

  seg7_scan_ctrl #(.DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_dark(input string tag);
    check({tag, " an_n"},  32'(bus_if.an_n), 32'hF);
    check({tag, " seg"},   32'(bus_if.seg), 32'h0);
    check({tag, " dp"},    32'(bus_if.dp), 32'h0);
    check({tag, " ack"},   32'(bus_if.load_ack), 32'h0);
    check({tag, " fs"},    32'(bus_if.frame_start), 32'h0);
  endtask

  // es packs the expected segments of digit k at es[7k +: 7].
  task automatic check_slot(input int p, input logic [27:0] es, input logic [3:0] edp,
                            input logic eack);
    int         idx;
    int         c;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    idx = p / 4;
    c   = p % 4;
    if (c == 0) begin
      e_an = 4'hF; e_seg = 7'h00; e_dp = 1'b0;
    end else begin
      e_an  = ~(4'b0001 << idx);
      e_seg = es[7*idx +: 7];
      e_dp  = edp[idx];
    end
    check($sformatf("an_n p%0d", p), 32'(bus_if.an_n), 32'(e_an));
    check($sformatf("seg p%0d", p),  32'(bus_if.seg), 32'(e_seg));
    check($sformatf("dp p%0d", p),   32'(bus_if.dp), 32'(e_dp));
    check($sformatf("fs p%0d", p),   32'(bus_if.frame_start), 32'(p == 0));
    check($sformatf("ack p%0d", p),  32'(bus_if.load_ack), 32'(eack && (p == 0)));
  endtask

  task automatic clr_loads();
    for (int k = 0; k < 3; k++) begin
      ld_p[k] = -1; ld_bcd[k] = 16'h0; ld_dp[k] = 4'h0;
    end
  endtask

  // Entered at the falling edge of slot 0; leaves at slot 0 of the next frame.
  task automatic scan_frame(input logic [27:0] es, input logic [3:0] edp, input logic eack);
    for (int p = 0; p < 16; p++) begin
      check_slot(p, es, edp, eack);
      bus_if.load = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (ld_p[k] == p) begin
          bus_if.load   = 1'b1;
          bus_if.bcd_in = ld_bcd[k];
          bus_if.dp_in  = ld_dp[k];
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    bus_if.en = 1'b1;
    bus_if.load = 1'b0;
    bus_if.bcd_in = 16'h0;
    bus_if.dp_in = 4'h0;
    bus_if.lzb = 1'b0;
    clr_loads();

    repeat (3) @(negedge clk);
    check_dark("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Frame 1: disp=0 -> "0000"; load 1234 mid-frame must not tear the display.
    ld_p[0] = 6; ld_bcd[0] = 16'h1234; ld_dp[0] = 4'b0001;
    scan_frame({4{7'h7E}}, 4'b0000, 1'b0);
    clr_loads();

    // Frame 2: transfer with ack; frame 3: same data, no second ack, load 0007.
    scan_frame({7'h30, 7'h6D, 7'h79, 7'h33}, 4'b0001, 1'b1);
    bus_if.lzb = 1'b1;
    ld_p[0] = 3; ld_bcd[0] = 16'h0007; ld_dp[0] = 4'b0000;
    scan_frame({7'h30, 7'h6D, 7'h79, 7'h33}, 4'b0001, 1'b0);
    clr_loads();

    // Frame 4: 0007 with leading-zero blanking.
    scan_frame({7'h00, 7'h00, 7'h00, 7'h70}, 4'b0000, 1'b1);

    // Frame 5: blanking off; 1111, 2222, then 3333 on the transfer edge.
    bus_if.lzb = 1'b0;
    ld_p[0] = 2;  ld_bcd[0] = 16'h1111;
    ld_p[1] = 9;  ld_bcd[1] = 16'h2222;
    ld_p[2] = 15; ld_bcd[2] = 16'h3333;
    scan_frame({7'h7E, 7'h7E, 7'h7E, 7'h70}, 4'b0000, 1'b0);
    clr_loads();
    scan_frame({4{7'h6D}}, 4'b0000, 1'b1);
    scan_frame({4{7'h79}}, 4'b0000, 1'b1);

    // Frame 8: freeze for 10 cycles after slot 5, load during the freeze.
    for (int p = 0; p < 6; p++) begin
      check_slot(p, {4{7'h79}}, 4'b0000, 1'b0);
      bus_if.load = 1'b0;
      if (p < 5) @(negedge clk);
    end
    bus_if.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_dark($sformatf("freeze %0d", i));
      bus_if.load = (i == 2);
      bus_if.bcd_in = 16'h5555;
      bus_if.dp_in = 4'b0000;
    end
    bus_if.load = 1'b0;
    bus_if.en = 1'b1;
    @(negedge clk);
    for (int p = 6; p < 16; p++) begin
      check_slot(p, {4{7'h79}}, 4'b0000, 1'b0);
      @(negedge clk);
    end

    // Frame 9: 5555 arrives; new load then async reset mid-SHOW.
    for (int p = 0; p < 6; p++) begin
      check_slot(p, {4{7'h5B}}, 4'b0000, 1'b1);
      bus_if.load = (p == 2);
      bus_if.bcd_in = 16'h9999;
      if (p < 5) @(negedge clk);
    end
    bus_if.load = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_dark("async rst");
    repeat (2) @(negedge clk);
    check_dark("rst hold");
    rst_n = 1'b1;
    @(negedge clk);

    // Pending 9999 must be gone: display 0000, no ack for two frames.
    scan_frame({4{7'h7E}}, 4'b0000, 1'b0);
    scan_frame({4{7'h7E}}, 4'b0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
